// File: rtl/otter_cu_pkg.sv
// Shared encodings for the OTTER multicycle control unit: opcodes, SYSTEM funct3 and sequencer states.
package otter_cu_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    F3_PRIV   = 3'b000,
    F3_CSRRW  = 3'b001,
    F3_CSRRS  = 3'b010,
    F3_CSRRC  = 3'b011,
    F3_CSRRWI = 3'b101,
    F3_CSRRSI = 3'b110,
    F3_CSRRCI = 3'b111
  } funct3_system_t;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_INTR
  } cu_state_t;

endpackage

// File: rtl/otter_irq_prio.sv
// Masked, globally-enabled interrupt priority encoder; the lowest-numbered active source wins.
module otter_irq_prio #(
  parameter int NUM_IRQ = 4,
  localparam int IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] mask_i,
  input  logic               mie_i,
  output logic               pending_o,
  output logic [IDW-1:0]     id_o
);

  logic [NUM_IRQ-1:0] active;

  always_comb begin
    active    = irq_i & mask_i;
    pending_o = mie_i & (|active);
    id_o      = '0;
    // Scan downward so the lowest set index is the last one written.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) id_o = IDW'(i);
    end
  end

endmodule

// File: rtl/otter_cu_fsm_ws.sv
// OTTER multicycle sequencer: fetch/exec/mem/writeback with wait-state memory handshake,
// bounded request timeout and interrupt entry at instruction boundaries.
module otter_cu_fsm_ws
  import otter_cu_pkg::*;
#(
  parameter int NUM_IRQ     = 4,
  parameter int MEM_TIMEOUT = 16,
  localparam int IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [6:0]         CU_OPCODE,
  input  logic [2:0]         CU_FUNC3,
  input  logic [NUM_IRQ-1:0] CU_IRQ,
  input  logic [NUM_IRQ-1:0] CU_IRQ_MASK,
  input  logic               CU_MIE,
  input  logic               CU_MEM_ACK,
  output logic               CU_MEM_RDEN1,
  output logic               CU_IR_WE,
  output logic               CU_MEM_RDEN2,
  output logic               CU_MEM_WE2,
  output logic               CU_PC_WE,
  output logic               CU_RF_WE,
  output logic               CU_CSR_WE,
  output logic               CU_INT_TAKEN,
  output logic [IDW-1:0]     CU_INT_ID,
  output logic               CU_MEM_TIMEOUT
);

  localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  cu_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             flag_q, flag_d;
  logic             irq_pending;
  logic [IDW-1:0]   irq_id;
  logic             done;
  logic             req;

  otter_irq_prio #(.NUM_IRQ(NUM_IRQ)) u_irq_prio (
    .irq_i     (CU_IRQ),
    .mask_i    (CU_IRQ_MASK),
    .mie_i     (CU_MIE),
    .pending_o (irq_pending),
    .id_o      (irq_id)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
      id_q    <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    flag_d       = flag_q;
    done         = 1'b0;
    CU_MEM_RDEN1 = 1'b0;
    CU_IR_WE     = 1'b0;
    CU_MEM_RDEN2 = 1'b0;
    CU_MEM_WE2   = 1'b0;
    CU_PC_WE     = 1'b0;
    CU_RF_WE     = 1'b0;
    CU_CSR_WE    = 1'b0;
    CU_INT_TAKEN = 1'b0;

    case (state_q)
      ST_FETCH: begin
        CU_MEM_RDEN1 = 1'b1;
        if (CU_MEM_ACK) begin
          CU_IR_WE = 1'b1;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (opcode_t'(CU_OPCODE))
          OPC_LOAD: begin
            CU_MEM_RDEN2 = 1'b1;
            state_d      = ST_MEM;
          end
          OPC_STORE: begin
            CU_MEM_WE2 = 1'b1;
            state_d    = ST_MEM;
          end
          OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
            CU_RF_WE = 1'b1;
            CU_PC_WE = 1'b1;
            done     = 1'b1;
          end
          OPC_SYSTEM: begin
            CU_PC_WE = 1'b1;
            // mret (funct3 000) only redirects the PC; CSR ops also write rd.
            if (funct3_system_t'(CU_FUNC3) != F3_PRIV) begin
              CU_RF_WE  = 1'b1;
              CU_CSR_WE = 1'b1;
            end
            done = 1'b1;
          end
          default: begin
            CU_PC_WE = 1'b1;
            done     = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        if (opcode_t'(CU_OPCODE) == OPC_STORE) begin
          CU_MEM_WE2 = 1'b1;
          if (CU_MEM_ACK) begin
            CU_PC_WE = 1'b1;
            done     = 1'b1;
          end
        end else begin
          CU_MEM_RDEN2 = 1'b1;
          if (CU_MEM_ACK) state_d = ST_WB;
        end
      end
      ST_WB: begin
        CU_RF_WE = 1'b1;
        CU_PC_WE = 1'b1;
        done     = 1'b1;
      end
      ST_INTR: begin
        CU_INT_TAKEN = 1'b1;
        CU_PC_WE     = 1'b1;
        state_d      = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase

    if (done) begin
      if (irq_pending) begin
        id_d    = irq_id;
        state_d = ST_INTR;
      end else begin
        state_d = ST_FETCH;
      end
    end

    // Counter only runs while a request sits in the same state unacknowledged.
    req = CU_MEM_RDEN1 | CU_MEM_RDEN2 | CU_MEM_WE2;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (req && !CU_MEM_ACK) begin
      if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
        flag_d  = 1'b1;
        cnt_d   = '0;
        state_d = ST_FETCH;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    CU_INT_ID      = id_q;
    CU_MEM_TIMEOUT = flag_q;
    if (RST) begin
      CU_MEM_RDEN1   = 1'b0;
      CU_IR_WE       = 1'b0;
      CU_MEM_RDEN2   = 1'b0;
      CU_MEM_WE2     = 1'b0;
      CU_PC_WE       = 1'b0;
      CU_RF_WE       = 1'b0;
      CU_CSR_WE      = 1'b0;
      CU_INT_TAKEN   = 1'b0;
      CU_INT_ID      = '0;
      CU_MEM_TIMEOUT = 1'b0;
    end
  end

endmodule

// File: tb/tb_otter_cu_fsm_ws.sv
// Scoreboard bench for otter_cu_fsm_ws: per-cycle expected control vectors queued with stimulus.
module tb_otter_cu_fsm_ws;

  localparam logic [10:0] R1  = 11'b100_0000_0000;
  localparam logic [10:0] IRW = 11'b010_0000_0000;
  localparam logic [10:0] R2  = 11'b001_0000_0000;
  localparam logic [10:0] W2  = 11'b000_1000_0000;
  localparam logic [10:0] PC  = 11'b000_0100_0000;
  localparam logic [10:0] RF  = 11'b000_0010_0000;
  localparam logic [10:0] CSR = 11'b000_0001_0000;
  localparam logic [10:0] IT  = 11'b000_0000_1000;
  localparam logic [10:0] NONE = 11'b0;

  localparam logic [6:0] OP_ADD    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BAD    = 7'b0000000;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [6:0] CU_OPCODE = OP_ADD;
  logic [2:0] CU_FUNC3 = 3'b000;
  logic [3:0] CU_IRQ = 4'b0000;
  logic [3:0] CU_IRQ_MASK = 4'b0000;
  logic       CU_MIE = 1'b0;
  logic       CU_MEM_ACK = 1'b0;
  logic       CU_MEM_RDEN1, CU_IR_WE, CU_MEM_RDEN2, CU_MEM_WE2;
  logic       CU_PC_WE, CU_RF_WE, CU_CSR_WE, CU_INT_TAKEN, CU_MEM_TIMEOUT;
  logic [1:0] CU_INT_ID;

  typedef struct {
    string       tag;
    logic [10:0] exp;
  } sb_t;

  sb_t        sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] eid = 2'd0;
  logic       eto = 1'b0;
  logic [10:0] obs;

  otter_cu_fsm_ws #(.NUM_IRQ(4), .MEM_TIMEOUT(16)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .CU_OPCODE      (CU_OPCODE),
    .CU_FUNC3       (CU_FUNC3),
    .CU_IRQ         (CU_IRQ),
    .CU_IRQ_MASK    (CU_IRQ_MASK),
    .CU_MIE         (CU_MIE),
    .CU_MEM_ACK     (CU_MEM_ACK),
    .CU_MEM_RDEN1   (CU_MEM_RDEN1),
    .CU_IR_WE       (CU_IR_WE),
    .CU_MEM_RDEN2   (CU_MEM_RDEN2),
    .CU_MEM_WE2     (CU_MEM_WE2),
    .CU_PC_WE       (CU_PC_WE),
    .CU_RF_WE       (CU_RF_WE),
    .CU_CSR_WE      (CU_CSR_WE),
    .CU_INT_TAKEN   (CU_INT_TAKEN),
    .CU_INT_ID      (CU_INT_ID),
    .CU_MEM_TIMEOUT (CU_MEM_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  assign obs = {CU_MEM_RDEN1, CU_IR_WE, CU_MEM_RDEN2, CU_MEM_WE2, CU_PC_WE,
                CU_RF_WE, CU_CSR_WE, CU_INT_TAKEN, CU_INT_ID, CU_MEM_TIMEOUT};

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", tag, got, want);
    end
  endtask

  // Queue the expected vector with the stimulus, compare mid-cycle, advance one clock.
  task automatic cyc(input logic ack, input string tag, input logic [10:0] ctrl);
    sb_t it;
    CU_MEM_ACK = ack;
    it.tag = tag;
    it.exp = RST ? NONE : (ctrl | {8'd0, eid, eto});
    sb.push_back(it);
    @(negedge CLK);
    it = sb.pop_front();
    check(it.tag, obs, it.exp);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_rst(input int n);
    RST = 1'b1;
    eid = 2'd0;
    eto = 1'b0;
    for (int i = 0; i < n; i++) cyc(1'b1, "reset", NONE);
    RST = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    @(posedge CLK);
    #1;
    do_rst(2);
    cyc(1'b0, "rel_fetch", R1);
    cyc(1'b1, "fetch_ack", R1 | IRW);
    cyc(1'b1, "add_exec", PC | RF);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, "add_fetch", R1 | IRW);
      cyc(1'b1, "add_exec", PC | RF);
    end

    CU_OPCODE = OP_LOAD;
    cyc(1'b1, "ld_fetch", R1 | IRW);
    cyc(1'b0, "ld_exec", R2);
    cyc(1'b0, "ld_mem_w0", R2);
    cyc(1'b0, "ld_mem_w1", R2);
    cyc(1'b1, "ld_mem_ack", R2);
    cyc(1'b1, "ld_wb", PC | RF);

    CU_OPCODE = OP_STORE;
    cyc(1'b1, "st_fetch", R1 | IRW);
    cyc(1'b0, "st_exec", W2);
    cyc(1'b0, "st_mem_w", W2);
    cyc(1'b1, "st_mem_ack", W2 | PC);
    cyc(1'b1, "st2_fetch", R1 | IRW);
    cyc(1'b1, "st2_exec", W2);
    cyc(1'b1, "st2_ack", W2 | PC);

    CU_OPCODE = OP_SYSTEM;
    CU_FUNC3  = 3'b000;
    cyc(1'b1, "mret_fetch", R1 | IRW);
    cyc(1'b1, "mret_exec", PC);
    CU_FUNC3 = 3'b001;
    cyc(1'b1, "csr_fetch", R1 | IRW);
    cyc(1'b1, "csr_exec", PC | RF | CSR);
    CU_OPCODE = OP_BRANCH;
    cyc(1'b1, "br_fetch", R1 | IRW);
    cyc(1'b1, "br_exec", PC);
    CU_OPCODE = OP_BAD;
    cyc(1'b1, "bad_fetch", R1 | IRW);
    cyc(1'b1, "bad_exec", PC);
    CU_OPCODE = OP_JAL;
    cyc(1'b1, "jal_fetch", R1 | IRW);
    cyc(1'b1, "jal_exec", PC | RF);

    CU_OPCODE = OP_ADD;
    CU_FUNC3 = 3'b000;
    CU_IRQ = 4'b0110;
    CU_IRQ_MASK = 4'b1111;
    CU_MIE = 1'b1;
    cyc(1'b1, "irq_fetch", R1 | IRW);
    cyc(1'b1, "irq_exec", PC | RF);
    eid = 2'd1;
    cyc(1'b1, "intr", IT | PC);
    cyc(1'b1, "post_intr_fetch", R1 | IRW);
    cyc(1'b1, "post_intr_exec", PC | RF);
    cyc(1'b1, "intr_again", IT | PC);
    CU_IRQ = 4'b1000;
    cyc(1'b1, "irq3_fetch", R1 | IRW);
    cyc(1'b1, "irq3_exec", PC | RF);
    eid = 2'd3;
    cyc(1'b1, "intr_id3", IT | PC);

    CU_IRQ = 4'b0110;
    CU_MIE = 1'b0;
    cyc(1'b1, "mie0_fetch", R1 | IRW);
    cyc(1'b1, "mie0_exec", PC | RF);
    cyc(1'b1, "mie0_no_intr", R1 | IRW);
    cyc(1'b1, "mie0_exec2", PC | RF);
    CU_MIE = 1'b1;
    CU_IRQ_MASK = 4'b1001;
    cyc(1'b1, "mask_fetch", R1 | IRW);
    cyc(1'b1, "mask_exec", PC | RF);
    cyc(1'b1, "mask_no_intr", R1 | IRW);

    CU_OPCODE = OP_LOAD;
    CU_IRQ = 4'b0001;
    CU_IRQ_MASK = 4'b1111;
    cyc(1'b1, "ldirq_exec", R2);
    cyc(1'b1, "ldirq_mem", R2);
    cyc(1'b1, "ldirq_wb", PC | RF);
    eid = 2'd0;
    cyc(1'b1, "ldirq_intr", IT | PC);
    CU_IRQ = 4'b0000;
    cyc(1'b1, "ldirq_fetch", R1 | IRW);

    RST = 1'b1;
    eid = 2'd0;
    cyc(1'b1, "rst_mid_exec", NONE);
    RST = 1'b0;
    cyc(1'b1, "rst_mid_fetch", R1 | IRW);
    cyc(1'b1, "rst_mid_exec2", R2);
    cyc(1'b1, "rst_mid_mem", R2);
    cyc(1'b1, "rst_mid_wb", PC | RF);

    cyc(1'b1, "mto_fetch", R1 | IRW);
    cyc(1'b0, "mto_exec", R2);
    for (int i = 0; i < 16; i++) cyc(1'b0, "mto_wait", R2);
    eto = 1'b1;
    cyc(1'b0, "mto_refetch", R1);
    cyc(1'b1, "mto_refetch_ack", R1 | IRW);
    do_rst(1);

    for (int i = 0; i < 16; i++) cyc(1'b0, "fto_wait", R1);
    eto = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, "fto_sticky", R1);
    CU_OPCODE = OP_ADD;
    cyc(1'b1, "fto_ack", R1 | IRW);
    cyc(1'b1, "fto_exec", PC | RF);
    do_rst(1);

    for (int i = 0; i < 15; i++) cyc(1'b0, "edge_wait", R1);
    cyc(1'b1, "edge_ack16", R1 | IRW);
    cyc(1'b1, "edge_exec", PC | RF);
    cyc(1'b0, "edge_fetch", R1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
